// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: writeback result select and default widths.
package cpu_types_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LUI  = 2'd2,
    WB_LINK = 2'd3
  } wb_sel_t;

endpackage

// File: rtl/writeback_stage_fwd_if.sv
// MEM->WB instruction bus, register-file write port and forwarding lookups.
interface writeback_stage_fwd_if
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NUM_RD = 2
);
  logic                     in_valid;
  logic                     in_wen;
  logic [1:0]               in_wsel;
  logic [REG_AW-1:0]        in_rd;
  logic [DATA_W-1:0]        in_alu;
  logic [DATA_W-1:0]        in_dload;
  logic [DATA_W-1:0]        in_imm;
  logic [DATA_W-1:0]        in_npc;
  logic                     in_halt;
  logic                     rf_wen;
  logic [REG_AW-1:0]        rf_wsel;
  logic [DATA_W-1:0]        rf_wdat;
  logic [NUM_RD*REG_AW-1:0] fwd_addr;
  logic [NUM_RD-1:0]        fwd_hit;
  logic [NUM_RD*DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_wen, in_wsel, in_rd, in_alu, in_dload, in_imm, in_npc, in_halt,
    output fwd_addr,
    input  rf_wen, rf_wsel, rf_wdat, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_wen, in_wsel, in_rd, in_alu, in_dload, in_imm, in_npc, in_halt,
    input  fwd_addr,
    output rf_wen, rf_wsel, rf_wdat, fwd_hit, fwd_data
  );
endinterface

// File: rtl/writeback_stage_fwd_history.sv
// Circular history of committed writes with NUM_RD combinational lookups;
// newest match wins, the in-flight write outranks the whole history.
module fwd_history #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [REG_AW-1:0]        wr_rd,
  input  logic [DATA_W-1:0]        wr_dat,
  input  logic [NUM_RD*REG_AW-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_hit,
  output logic [NUM_RD*DATA_W-1:0] lk_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_AW-1:0] ent_rd  [DEPTH];
  logic [DATA_W-1:0] ent_dat [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  wptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      wptr    <= '0;
    end else if (wr_en) begin
      ent_rd[wptr]  <= wr_rd;
      ent_dat[wptr] <= wr_dat;
      ent_vld[wptr] <= 1'b1;
      wptr          <= (int'(wptr) == DEPTH - 1) ? '0 : wptr + 1'b1;
    end
  end

  logic [REG_AW-1:0] addr;
  logic [PTR_W-1:0]  idx;

  always_comb begin
    lk_hit = '0;
    lk_dat = '0;
    addr   = '0;
    idx    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = lk_addr[p*REG_AW +: REG_AW];
      // Walk oldest to newest so later matches overwrite earlier ones.
      for (int k = 0; k < DEPTH; k++) begin
        idx = PTR_W'((int'(wptr) + k) % DEPTH);
        if (ent_vld[idx] && ent_rd[idx] == addr) begin
          lk_hit[p]                  = 1'b1;
          lk_dat[p*DATA_W +: DATA_W] = ent_dat[idx];
        end
      end
      if (wr_en && wr_rd == addr) begin
        lk_hit[p]                  = 1'b1;
        lk_dat[p*DATA_W +: DATA_W] = wr_dat;
      end
      if (addr == '0) begin
        lk_hit[p]                  = 1'b0;
        lk_dat[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

endmodule

// File: rtl/writeback_stage_fwd.sv
// MEM/WB register, result mux, sticky halt and retire counter; rf_* valid one
// cycle after capture. stall/flush/halt load a bubble; upstream holds its own latch.
module writeback_stage_fwd
  import cpu_types_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int FWD_DEPTH = 4,
  parameter int NUM_RD    = 2,
  parameter int CNT_W     = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stall,
  input  logic               flush,
  writeback_stage_fwd_if.slave bus,
  output logic               halt,
  output logic [CNT_W-1:0]   retired
);
  logic              v_q;
  logic              wen_q;
  logic              halt_q;
  logic              halt_sticky;
  wb_sel_t           wsel_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] dload_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] npc_q;

  logic              wr_en;
  logic [DATA_W-1:0] wb_val;

  assign halt = halt_sticky | (v_q & halt_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q         <= 1'b0;
      wen_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_sticky <= 1'b0;
      wsel_q      <= WB_ALU;
      rd_q        <= '0;
      alu_q       <= '0;
      dload_q     <= '0;
      imm_q       <= '0;
      npc_q       <= '0;
      retired     <= '0;
    end else begin
      if (v_q) retired <= retired + 1'b1;
      if (v_q && halt_q) halt_sticky <= 1'b1;
      if (stall || flush || halt) begin
        v_q <= 1'b0;
      end else begin
        v_q     <= bus.in_valid;
        wen_q   <= bus.in_wen;
        halt_q  <= bus.in_halt;
        wsel_q  <= wb_sel_t'(bus.in_wsel);
        rd_q    <= bus.in_rd;
        alu_q   <= bus.in_alu;
        dload_q <= bus.in_dload;
        imm_q   <= bus.in_imm;
        npc_q   <= bus.in_npc;
      end
    end
  end

  always_comb begin
    wb_val = alu_q;
    case (wsel_q)
      WB_ALU:  wb_val = alu_q;
      WB_LOAD: wb_val = dload_q;
      WB_LUI:  wb_val = imm_q;
      WB_LINK: wb_val = npc_q;
      default: wb_val = alu_q;
    endcase
  end

  // HALT never writes, and r0 writes are dropped so r0 reads stay zero.
  assign wr_en       = v_q & wen_q & ~halt_q & (rd_q != '0);
  assign bus.rf_wen  = wr_en;
  assign bus.rf_wsel = wr_en ? rd_q : '0;
  assign bus.rf_wdat = wr_en ? wb_val : '0;

  fwd_history #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (FWD_DEPTH),
    .NUM_RD (NUM_RD)
  ) u_hist (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_en),
    .wr_rd   (rd_q),
    .wr_dat  (wb_val),
    .lk_addr (bus.fwd_addr),
    .lk_hit  (bus.fwd_hit),
    .lk_dat  (bus.fwd_data)
  );

endmodule

// File: tb/tb_writeback_stage_fwd.sv
// Table-driven directed rows plus randomized traffic against a queue-based model.
module tb_writeback_stage_fwd;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int NR = 2;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          stall;
  logic          flush;
  logic          halt;
  logic [CW-1:0] retired;

  writeback_stage_fwd_if #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR)) bus ();

  writeback_stage_fwd #(
    .DATA_W(DW), .REG_AW(AW), .FWD_DEPTH(FD), .NUM_RD(NR), .CNT_W(CW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .stall   (stall),
    .flush   (flush),
    .bus     (bus),
    .halt    (halt),
    .retired (retired)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stage contents, list of committed writes, halt, count.
  typedef struct {
    bit          v;
    bit          wen;
    bit          h;
    int          sel;
    int          rd;
    logic [31:0] alu;
    logic [31:0] dl;
    logic [31:0] imm;
    logic [31:0] npc;
  } ins_t;

  typedef struct {
    int          rd;
    logic [31:0] dat;
  } wr_t;

  ins_t          st;
  wr_t           hist[$];
  bit            sticky;
  logic [CW-1:0] mret;

  function automatic bit m_wen();
    return st.v && st.wen && !st.h && st.rd != 0;
  endfunction

  function automatic logic [31:0] m_val();
    case (st.sel)
      0:       return st.alu;
      1:       return st.dl;
      2:       return st.imm;
      default: return st.npc;
    endcase
  endfunction

  function automatic logic [31:0] m_wdat();
    return m_wen() ? m_val() : 32'd0;
  endfunction

  function automatic bit m_halt();
    return sticky || (st.v && st.h);
  endfunction

  function automatic logic [32:0] m_look(input int a);
    if (a == 0) return 33'd0;
    if (m_wen() && st.rd == a) return {1'b1, m_val()};
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i].rd == a) return {1'b1, hist[i].dat};
    return 33'd0;
  endfunction

  task automatic apply(input bit r, input bit s, input bit f, input ins_t x,
                       input int a0, input int a1);
    bit          bubble;
    logic [32:0] l0;
    logic [32:0] l1;
    RST           = r;
    stall         = s;
    flush         = f;
    bus.in_valid  = x.v;
    bus.in_wen    = x.wen;
    bus.in_halt   = x.h;
    bus.in_wsel   = 2'(x.sel);
    bus.in_rd     = 5'(x.rd);
    bus.in_alu    = x.alu;
    bus.in_dload  = x.dl;
    bus.in_imm    = x.imm;
    bus.in_npc    = x.npc;
    bus.fwd_addr  = {5'(a1), 5'(a0)};
    @(posedge CLK);
    if (r) begin
      st     = '{default: 0};
      hist.delete();
      sticky = 1'b0;
      mret   = '0;
    end else begin
      bubble = s || f || m_halt();
      if (m_wen()) begin
        hist.push_back('{st.rd, m_wdat()});
        if (hist.size() > FD) void'(hist.pop_front());
      end
      if (st.v) mret++;
      if (st.v && st.h) sticky = 1'b1;
      if (bubble) st = '{default: 0};
      else        st = x;
    end
    @(negedge CLK);
    l0 = m_look(a0);
    l1 = m_look(a1);
    chk("m_rf_wen",  64'(bus.rf_wen),  64'(m_wen()));
    chk("m_rf_wsel", 64'(bus.rf_wsel), m_wen() ? 64'(st.rd) : 64'd0);
    chk("m_rf_wdat", 64'(bus.rf_wdat), 64'(m_wdat()));
    chk("m_fwd_hit", 64'(bus.fwd_hit), 64'({l1[32], l0[32]}));
    chk("m_fwd_d0",  64'(bus.fwd_data[31:0]),  64'(l0[31:0]));
    chk("m_fwd_d1",  64'(bus.fwd_data[63:32]), 64'(l1[31:0]));
    chk("m_halt",    64'(halt),    64'(m_halt()));
    chk("m_retired", 64'(retired), 64'(mret));
  endtask

  // Directed rows: inputs, then outputs expected in the cycle after the edge.
  // Sources per row: alu=dat, dload=dat+1, imm=dat+2, npc=dat+3.
  typedef struct {
    int r, s, f, v, w, sel, rd, dat, h, a0, a1;
    int ew, ews, ewd, ehit, ed0, ed1, ehalt, eret;
  } row_t;

  row_t rows[$];

  task automatic add(input int r, s, f, v, w, sel, rd, dat, h, a0, a1,
                     input int ew, ews, ewd, ehit, ed0, ed1, ehalt, eret);
    rows.push_back('{r, s, f, v, w, sel, rd, dat, h, a0, a1,
                     ew, ews, ewd, ehit, ed0, ed1, ehalt, eret});
  endtask

  initial begin
    ins_t x;
    //   r s f v w sel rd dat      h a0 a1   ew ews ewd      hit d0     d1     hl ret
    add(1,0,0,0,0,0, 0, 0,       0, 0, 0,  0, 0, 0,       0, 0,     0,     0, 0);
    add(0,0,0,1,1,0, 3, 'hAA,    0, 3, 0,  1, 3, 'hAA,    1, 'hAA,  0,     0, 0);
    add(0,0,0,1,1,1, 0, 'h54,    0, 0, 3,  0, 0, 0,       2, 0,     'hAA,  0, 1);
    add(0,0,0,1,1,0, 5, 'h11,    0, 5, 7,  1, 5, 'h11,    1, 'h11,  0,     0, 2);
    add(0,0,0,1,1,2, 6, 'h5FFE,  0, 5, 7,  1, 6, 'h6000,  1, 'h11,  0,     0, 3);
    add(0,0,0,1,1,3, 7, 'h101,   0, 5, 7,  1, 7, 'h104,   3, 'h11,  'h104, 0, 4);
    add(0,0,0,1,1,0, 5, 'h22,    0, 5, 7,  1, 5, 'h22,    3, 'h22,  'h104, 0, 5);
    add(0,0,0,0,0,0, 0, 0,       0, 5, 7,  0, 0, 0,       3, 'h22,  'h104, 0, 6);
    add(0,0,0,1,1,0, 1, 'h101,   0, 1, 2,  1, 1, 'h101,   1, 'h101, 0,     0, 6);
    add(0,0,0,1,1,0, 2, 'h102,   0, 1, 2,  1, 2, 'h102,   3, 'h101, 'h102, 0, 7);
    add(0,0,0,1,1,0, 3, 'h103,   0, 1, 2,  1, 3, 'h103,   3, 'h101, 'h102, 0, 8);
    add(0,0,0,1,1,0, 4, 'h104,   0, 1, 2,  1, 4, 'h104,   3, 'h101, 'h102, 0, 9);
    add(0,0,0,1,1,0, 5, 'h105,   0, 1, 2,  1, 5, 'h105,   3, 'h101, 'h102, 0, 10);
    add(0,0,0,0,0,0, 0, 0,       0, 1, 2,  0, 0, 0,       2, 0,     'h102, 0, 11);
    add(0,1,0,1,1,0, 9, 'h99,    0, 9, 0,  0, 0, 0,       0, 0,     0,     0, 11);
    add(0,0,1,1,1,0, 9, 'h99,    0, 9, 0,  0, 0, 0,       0, 0,     0,     0, 11);
    add(0,1,1,1,1,0, 9, 'h99,    0, 9, 0,  0, 0, 0,       0, 0,     0,     0, 11);
    add(0,0,0,1,1,0, 8, 'h88,    1, 8, 0,  0, 0, 0,       0, 0,     0,     1, 11);
    add(0,0,0,1,1,0, 8, 'h77,    0, 8, 0,  0, 0, 0,       0, 0,     0,     1, 12);
    add(0,0,0,1,1,0, 8, 'h66,    0, 8, 0,  0, 0, 0,       0, 0,     0,     1, 12);
    add(1,0,0,1,1,0, 8, 'h55,    0, 5, 2,  0, 0, 0,       0, 0,     0,     0, 0);
    add(0,0,0,1,1,0, 4, 'h44,    0, 4, 0,  1, 4, 'h44,    1, 'h44,  0,     0, 0);
    add(1,0,0,0,0,0, 0, 0,       0, 4, 0,  0, 0, 0,       0, 0,     0,     0, 0);
    add(0,0,0,0,0,0, 0, 0,       0, 4, 0,  0, 0, 0,       0, 0,     0,     0, 0);

    st     = '{default: 0};
    sticky = 1'b0;
    mret   = '0;
    @(negedge CLK);

    foreach (rows[i]) begin
      x.v   = rows[i].v != 0;
      x.wen = rows[i].w != 0;
      x.h   = rows[i].h != 0;
      x.sel = rows[i].sel;
      x.rd  = rows[i].rd;
      x.alu = 32'(rows[i].dat);
      x.dl  = 32'(rows[i].dat + 1);
      x.imm = 32'(rows[i].dat + 2);
      x.npc = 32'(rows[i].dat + 3);
      apply(rows[i].r != 0, rows[i].s != 0, rows[i].f != 0, x, rows[i].a0, rows[i].a1);
      chk($sformatf("row%0d_wen", i),  64'(bus.rf_wen),  64'(rows[i].ew));
      chk($sformatf("row%0d_wsel", i), 64'(bus.rf_wsel), 64'(rows[i].ews));
      chk($sformatf("row%0d_wdat", i), 64'(bus.rf_wdat), 64'(rows[i].ewd));
      chk($sformatf("row%0d_hit", i),  64'(bus.fwd_hit), 64'(rows[i].ehit));
      chk($sformatf("row%0d_d0", i),   64'(bus.fwd_data[31:0]),  64'(rows[i].ed0));
      chk($sformatf("row%0d_d1", i),   64'(bus.fwd_data[63:32]), 64'(rows[i].ed1));
      chk($sformatf("row%0d_halt", i), 64'(halt),    64'(rows[i].ehalt));
      chk($sformatf("row%0d_ret", i),  64'(retired), 64'(rows[i].eret));
    end

    // Random traffic over a small register range to force aliasing in the history.
    for (int n = 0; n < 600; n++) begin
      x.v   = $urandom_range(0, 3) != 0;
      x.wen = $urandom_range(0, 3) != 0;
      x.h   = $urandom_range(0, 39) == 0;
      x.sel = int'($urandom_range(0, 3));
      x.rd  = int'($urandom_range(0, 7));
      x.alu = $urandom;
      x.dl  = $urandom;
      x.imm = $urandom;
      x.npc = $urandom;
      apply($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, x,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
